// File: rtl/modulator_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : modulator_pkg
// Description : Mode/frequency codes, FSM encoding and sizing helpers shared
//               by the frame scheduler and its bit period timer.
// Revision    : 1.0
// ============================================================================
package modulator_pkg;

  localparam logic [1:0] MOD_FSK  = 2'd0;
  localparam logic [1:0] MOD_ASK  = 2'd1;
  localparam logic [1:0] MOD_BPSK = 2'd2;
  localparam logic [1:0] MOD_QPSK = 2'd3;

  localparam logic [1:0] FREQ_SEL_0 = 2'd0;
  localparam logic [1:0] FREQ_SEL_1 = 2'd1;
  localparam logic [1:0] FREQ_SEL_2 = 2'd2;
  localparam logic [1:0] FREQ_SEL_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_STALL = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter must hold (max count - 1); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage : modulator_pkg
`default_nettype wire

// File: rtl/bit_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_period_timer
// Description : Loadable down-counter; tc_o flags the final cycle of a load.
// Revision    : 1.0
// ============================================================================
module bit_period_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic             run_q;

  // A load of N yields N+1 cycles, the last one carrying tc_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (load_i) begin
      count_q <= load_val_i;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (count_q == '0) begin
        run_q <= 1'b0;
      end else begin
        count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign tc_o = run_q && (count_q == '0);

endmodule : bit_period_timer
`default_nettype wire

// File: rtl/modulator_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : modulator_frame_scheduler
// Description : Pulls payload bytes from a stream and serialises them
//               MSB-first onto the modulator Din with a mode-dependent period.
// Revision    : 1.0
// ============================================================================
module modulator_frame_scheduler
  import modulator_pkg::*;
#(
  parameter int BIT_PERIOD      = 512,
  parameter int QPSK_BIT_PERIOD = 64,
  parameter int GAP_CYCLES      = 16,
  parameter int LEN_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_mod,
  input  logic [1:0]       cfg_freq,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             din,
  output logic [1:0]       mod_sel,
  output logic [1:0]       freq_sel,
  output logic             bit_strobe,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned CNT_W = cnt_width(BIT_PERIOD, QPSK_BIT_PERIOD, GAP_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] QPSK_LOAD = CNT_W'(QPSK_BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       mod_q, mod_d;
  logic [1:0]       freq_q, freq_d;
  logic [LEN_W-1:0] fetch_left_q, fetch_left_d;
  logic [LEN_W-1:0] send_left_q, send_left_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             din_q, din_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic             in_frame;
  logic             ready_int;
  logic             handshake;
  logic             accept_start;
  logic             resume;
  logic             next_bit;
  logic             boundary;
  logic             frame_last;
  logic             load_shift;
  logic             done_int;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] period_load;
  logic             tmr_tc;

  bit_period_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign in_frame     = (state_q != ST_IDLE);
  assign ready_int    = in_frame && !hold_full_q && (fetch_left_q != '0);
  assign handshake    = byte_valid && ready_int;
  assign accept_start = (state_q == ST_IDLE) && start && (frame_len != '0);
  assign resume       = ((state_q == ST_FETCH) || (state_q == ST_STALL)) && hold_full_q;
  assign next_bit     = (state_q == ST_SEND) && tmr_tc && (bit_idx_q != 3'd0);
  assign boundary     = (state_q == ST_SEND) && tmr_tc && (bit_idx_q == 3'd0);
  assign frame_last   = (send_left_q == LEN_ONE);
  assign load_shift   = resume || (boundary && !frame_last && hold_full_q);
  assign period_load  = (mod_q == MOD_QPSK) ? QPSK_LOAD : BIT_LOAD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_start) state_d = ST_FETCH;
      ST_FETCH: if (hold_full_q)  state_d = ST_SEND;
      ST_STALL: if (hold_full_q)  state_d = ST_SEND;
      ST_SEND: begin
        if (boundary) begin
          if (frame_last)       state_d = ST_GAP;
          else if (!hold_full_q) state_d = ST_STALL;
        end
      end
      ST_GAP:   if (tmr_tc)       state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state and the timer command, decoded from registered state.
  always_comb begin
    mod_d        = mod_q;
    freq_d       = freq_q;
    fetch_left_d = fetch_left_q;
    send_left_d  = send_left_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    din_d        = din_q;
    strobe_d     = 1'b0;
    underrun_d   = underrun_q;
    tmr_load     = 1'b0;
    tmr_val      = period_load;
    done_int     = (state_q == ST_GAP) && tmr_tc;

    if (accept_start) begin
      mod_d        = cfg_mod;
      freq_d       = cfg_freq;
      fetch_left_d = frame_len;
      send_left_d  = frame_len;
      underrun_d   = 1'b0;
    end

    if (handshake) begin
      hold_d       = byte_data;
      hold_full_d  = 1'b1;
      fetch_left_d = fetch_left_q - LEN_ONE;
    end

    if (boundary) begin
      send_left_d = send_left_q - LEN_ONE;
    end

    if (load_shift) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_idx_d   = 3'd7;
      din_d       = hold_q[7];
      strobe_d    = 1'b1;
      tmr_load    = 1'b1;
    end else if (next_bit) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_idx_d = bit_idx_q - 3'd1;
      din_d     = shift_q[6];
      strobe_d  = 1'b1;
      tmr_load  = 1'b1;
    end else if (boundary) begin
      din_d = 1'b0;
      if (frame_last) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q        <= MOD_FSK;
      freq_q       <= FREQ_SEL_0;
      fetch_left_q <= '0;
      send_left_q  <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      din_q        <= 1'b0;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mod_q        <= mod_d;
      freq_q       <= freq_d;
      fetch_left_q <= fetch_left_d;
      send_left_q  <= send_left_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      din_q        <= din_d;
      strobe_q     <= strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  assign byte_ready = ready_int;
  assign din        = din_q;
  assign mod_sel    = mod_q;
  assign freq_sel   = freq_q;
  assign bit_strobe = strobe_q;
  assign busy       = in_frame;
  assign frame_done = done_int;
  assign underrun   = underrun_q;

endmodule : modulator_frame_scheduler
`default_nettype wire

// File: tb/tb_modulator_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulator_frame_scheduler
// Description : Scoreboard bench: expected bits/frame ends queued per frame,
//               popped by a monitor on bit_strobe and frame_done.
// Revision    : 1.0
// ============================================================================
module tb_modulator_frame_scheduler;

  localparam int BP    = 40;
  localparam int QP    = 8;
  localparam int GAP   = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       cfg_mod;
  logic [1:0]       cfg_freq;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
  logic             din;
  logic [1:0]       mod_sel;
  logic [1:0]       freq_sel;
  logic             bit_strobe;
  logic             busy;
  logic             frame_done;
  logic             underrun;

  modulator_frame_scheduler #(
    .BIT_PERIOD      (BP),
    .QPSK_BIT_PERIOD (QP),
    .GAP_CYCLES      (GAP),
    .LEN_W           (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_mod    (cfg_mod),
    .cfg_freq   (cfg_freq),
    .frame_len  (frame_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .din        (din),
    .mod_sel    (mod_sel),
    .freq_sel   (freq_sel),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [1:0] m;
    logic [1:0] f;
    int         delta;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  logic prev_din = 1'b0;

  // Monitor: compares every new bit and every frame end against the queues.
  always @(negedge clk) begin
    exp_t e;
    int   want;
    if (rst_n === 1'b1) begin
      cyc++;
      if (bit_strobe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: strobe at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (din !== e.b || mod_sel !== e.m || freq_sel !== e.f) begin
            errors++;
            $display("FAIL strobe_bit: din=%b mod=%0d freq=%0d, expected din=%b mod=%0d freq=%0d",
                     din, mod_sel, freq_sel, e.b, e.m, e.f);
          end
          if (e.delta != 0) begin
            checks++;
            if (cyc - last_strobe != e.delta) begin
              errors++;
              $display("FAIL bit_period: %0d cycles, expected %0d", cyc - last_strobe, e.delta);
            end
          end
        end
        last_strobe = cyc;
      end else if (busy === 1'b1) begin
        checks++;
        if (din !== prev_din && din !== 1'b0) begin
          errors++;
          $display("FAIL din_glitch: din rose to %b without bit_strobe at cycle %0d", din, cyc);
        end
      end
      if (frame_done === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: frame_done at cycle %0d, expected none", cyc);
        end else begin
          want = done_q.pop_front();
          if (cyc - last_strobe != want) begin
            errors++;
            $display("FAIL done_timing: %0d cycles after last bit start, expected %0d",
                     cyc - last_strobe, want);
          end
        end
      end
      prev_din = din;
    end else begin
      prev_din = 1'b0;
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic [1:0] m, input logic [1:0] f,
                           input int p, input int first_delta);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b     = d[i];
      e.m     = m;
      e.f     = f;
      e.delta = (i == 7) ? first_delta : p;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done(input int p);
    done_q.push_back(p + GAP - 1);
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [1:0] f, input logic [LEN_W-1:0] len);
    @(negedge clk);
    cfg_mod   = m;
    cfg_freq  = f;
    frame_len = len;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input int budget);
    bit got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = d;
    for (int i = 0; i < budget && !got; i++) begin
      if (byte_ready === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL feed_accept: byte %h not accepted, expected within %0d cycles", d, budget);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_done_timeout: no frame_done, expected within %0d cycles", budget);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: busy=%b, expected 0", busy);
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d bits and %0d ends outstanding, expected 0 and 0",
               exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({din, mod_sel, freq_sel, byte_ready, bit_strobe, busy, frame_done, underrun} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: %b, expected 0000000000",
               {din, mod_sel, freq_sel, byte_ready, bit_strobe, busy, frame_done, underrun});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ask_single();
    push_byte(8'hA5, 2'd1, 2'd2, BP, 0);
    push_done(BP);
    start_frame(2'd1, 2'd2, 8'd1);
    checks++;
    if (busy !== 1'b1 || mod_sel !== 2'd1 || freq_sel !== 2'd2 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL ask_start: busy=%b mod=%0d freq=%0d ready=%b, expected 1 1 2 1",
               busy, mod_sel, freq_sel, byte_ready);
    end
    feed(8'hA5, 10);
    wait_done(8 * BP + GAP + 20);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ask_underrun: underrun=%b, expected 0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    push_byte(8'h3C, 2'd3, 2'd1, QP, 0);
    push_byte(8'hF0, 2'd3, 2'd1, QP, QP);
    push_done(QP);
    start_frame(2'd3, 2'd1, 8'd2);
    feed(8'h3C, 10);
    feed(8'hF0, 4 * QP);
    checks++;
    if (exp_q.size() <= 8) begin
      errors++;
      $display("FAIL b2b_prefetch: %0d bits pending at second accept, expected more than 8",
               exp_q.size());
    end
    wait_done(16 * QP + GAP + 20);
  endtask

  task automatic test_underrun();
    bit seen = 1'b0;
    push_byte(8'hFF, 2'd0, 2'd3, BP, 0);
    push_byte(8'h81, 2'd0, 2'd3, BP, 0);
    push_done(BP);
    start_frame(2'd0, 2'd3, 8'd2);
    feed(8'hFF, 10);
    for (int i = 0; i < 8 * BP + 10 && !seen; i++) begin
      if (underrun === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || din !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1 || exp_q.size() != 8) begin
      errors++;
      $display("FAIL underrun_flag: seen=%b din=%b busy=%b ready=%b pending=%0d, expected 1 0 1 1 8",
               seen, din, busy, byte_ready, exp_q.size());
    end
    repeat (99) @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || din !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL underrun_stall: underrun=%b din=%b busy=%b, expected 1 0 1", underrun, din, busy);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h81;
    @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (bit_strobe !== 1'b0 || din !== 1'b0) begin
      errors++;
      $display("FAIL resume_early: strobe=%b din=%b, expected 0 0", bit_strobe, din);
    end
    @(negedge clk);
    checks++;
    if (bit_strobe !== 1'b1 || din !== 1'b1) begin
      errors++;
      $display("FAIL resume_timing: strobe=%b din=%b, expected 1 1", bit_strobe, din);
    end
    wait_done(8 * BP + GAP + 20);
    repeat (5) @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: underrun=%b, expected 1", underrun);
    end
    push_byte(8'h5A, 2'd1, 2'd0, BP, 0);
    push_done(BP);
    start_frame(2'd1, 2'd0, 8'd1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: underrun=%b, expected 0", underrun);
    end
    feed(8'h5A, 10);
    wait_done(8 * BP + GAP + 20);
  endtask

  task automatic test_ignored();
    start_frame(2'd2, 2'd1, 8'd0);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: busy=%b ready=%b, expected 0 0", busy, byte_ready);
    end
    push_byte(8'h3C, 2'd1, 2'd2, BP, 0);
    push_done(BP);
    start_frame(2'd1, 2'd2, 8'd1);
    feed(8'h3C, 10);
    repeat (2 * BP) @(negedge clk);
    start_frame(2'd3, 2'd0, 8'd5);
    checks++;
    if (mod_sel !== 2'd1 || freq_sel !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: mod=%0d freq=%0d busy=%b, expected 1 2 1", mod_sel, freq_sel, busy);
    end
    wait_done(8 * BP + GAP + 20);
    repeat (50) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL after_ignored: busy=%b ready=%b, expected 0 0", busy, byte_ready);
    end
  endtask

  task automatic test_reset_midframe();
    int strobes = 0;
    push_byte(8'h55, 2'd2, 2'd1, BP, 0);
    push_done(BP);
    start_frame(2'd2, 2'd1, 8'd1);
    feed(8'h55, 10);
    for (int i = 0; i < 6 * BP && strobes < 4; i++) begin
      @(negedge clk);
      if (bit_strobe === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 4) begin
      errors++;
      $display("FAIL reach_bit3: %0d strobes, expected 4", strobes);
    end
    repeat (BP / 2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    checks++;
    if ({din, mod_sel, freq_sel, byte_ready, bit_strobe, busy, frame_done, underrun} !== 10'b0) begin
      errors++;
      $display("FAIL midframe_reset: %b, expected 0000000000",
               {din, mod_sel, freq_sel, byte_ready, bit_strobe, busy, frame_done, underrun});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BP) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b, expected 0", busy);
    end
    push_byte(8'hC3, 2'd2, 2'd1, BP, 0);
    push_done(BP);
    start_frame(2'd2, 2'd1, 8'd1);
    feed(8'hC3, 10);
    wait_done(8 * BP + GAP + 20);
  endtask

  task automatic test_mode_sweep();
    logic [1:0] mm;
    logic [1:0] ff;
    int         p;
    for (int m = 0; m < 4; m++) begin
      for (int f = 0; f < 4; f++) begin
        mm = m[1:0];
        ff = f[1:0];
        p  = (m == 3) ? QP : BP;
        push_byte(8'h81, mm, ff, p, 0);
        push_done(p);
        start_frame(mm, ff, 8'd1);
        checks++;
        if (mod_sel !== mm || freq_sel !== ff) begin
          errors++;
          $display("FAIL sweep_cfg: mod=%0d freq=%0d, expected %0d %0d", mod_sel, freq_sel, mm, ff);
        end
        feed(8'h81, 10);
        wait_done(8 * p + GAP + 20);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_mod    = 2'd0;
    cfg_freq   = 2'd0;
    frame_len  = '0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_ask_single();
    test_back_to_back();
    test_underrun();
    test_ignored();
    test_reset_midframe();
    test_mode_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_modulator_frame_scheduler
`default_nettype wire
